lsu: RTL and testbench

- Load/store unit; the memory stage directly downstream of ctrl in the RV64 core.
- Consumes the ALU-computed address (rd_mem_addr), store data (rs2) and access size. It runs one transaction on a simple request/grant/response data bus.
- Returns lane-aligned, zero-extended read data to ctrl's mem_rd_data; ctrl keeps ownership of sign extension.
- Stalls the core (PC/regfile write enable) until the access completes.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu.sv | 177 +++++++++++++++++
 tb/tb_lsu.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions.
// Holds the access-size encodings, the LSU state enum and the byte-strobe masks
// for each size. Imported by lsu_align and lsu.
package lsu_pkg;

    // Access size encodings (req_size)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Unshifted byte-strobe masks per size
    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the LSU (master) and memory (slave).
// Signals:
//   bus_req    master->slave  request valid, held until bus_gnt
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  doubleword-aligned address
//   bus_wdata  master->slave  lane-aligned write data
//   bus_wstrb  master->slave  byte strobes
//   bus_gnt    slave->master  request accepted this cycle
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  doubleword-aligned read data
interface lsu_if #(
    parameter int unsigned ADDR_W = 64
) ();
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [63:0]       bus_wdata;
    logic [7:0]        bus_wstrb;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [63:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment for the LSU.
// Ports:
//   size_i     access size (SZ_B/H/W/D)
//   offset_i   byte offset within the doubleword (addr[2:0])
//   wdata_i    right-aligned store data
//   rdata_i    doubleword-aligned read data from the bus
//   wstrb_o    size mask shifted to the byte lane
//   wdata_o    store data shifted to the byte lane
//   misalign_o address not naturally aligned for size_i
//   rdata_o    read data shifted down to bit 0, bytes above size zeroed
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wstrb_o,
    output logic [63:0] wdata_o,
    output logic        misalign_o,
    output logic [63:0] rdata_o
);

    logic [7:0]  size_mask;
    logic [63:0] bit_mask;
    logic [63:0] rdata_sh;

    always_comb begin
        size_mask  = STRB_B;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_B: begin
                size_mask  = STRB_B;
                misalign_o = 1'b0;
            end
            SZ_H: begin
                size_mask  = STRB_H;
                misalign_o = offset_i[0];
            end
            SZ_W: begin
                size_mask  = STRB_W;
                misalign_o = |offset_i[1:0];
            end
            SZ_D: begin
                size_mask  = STRB_D;
                misalign_o = |offset_i;
            end
        endcase

        // Expand the byte mask to a bit mask for zero-extension of read data
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{size_mask[i]}};
        end

        wstrb_o  = size_mask << offset_i;
        wdata_o  = wdata_i << {offset_i, 3'b000};
        rdata_sh = rdata_i >> {offset_i, 3'b000};
        rdata_o  = rdata_sh & bit_mask;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: memory stage after ctrl. Runs one access per memory
// instruction on a request/grant/response bus and stalls the core until done.
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   req_*         memory instruction (valid, write, size, address, store data)
//   stall         freeze PC and regfile write while the access is in flight
//   done          one-cycle completion pulse; misalign/bus_err/mem_rd_data valid with it
//   mem_rd_data   lane-extracted, zero-extended load data (sign extension is ctrl's job)
//   bus           lsu_if master modport
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic              misalign,
    output logic              bus_err,
    output logic [63:0]       mem_rd_data,
    lsu_if.master             bus
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic [CntW-1:0]   cnt_q;
    logic              done_q;
    logic              misalign_q;
    logic              bus_err_q;
    logic [63:0]       rd_data_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [63:0]       bus_wdata_q;
    logic [7:0]        bus_wstrb_q;

    logic              in_idle;
    logic [1:0]        al_size;
    logic [2:0]        al_off;
    logic [7:0]        al_wstrb;
    logic [63:0]       al_wdata;
    logic              al_misalign;
    logic [63:0]       al_rdata;

    // In IDLE the aligner sees the incoming request; afterwards the captured one
    assign in_idle = (state_q == StIdle);
    assign al_size = in_idle ? req_size : size_q;
    assign al_off  = in_idle ? req_addr[2:0] : off_q;

    lsu_align u_align (
        .size_i     (al_size),
        .offset_i   (al_off),
        .wdata_i    (req_wdata),
        .rdata_i    (bus.bus_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .misalign_o (al_misalign),
        .rdata_o    (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            rd_data_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
        end else begin
            // Completion outputs are single-cycle unless set below
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            rd_data_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        wr_q   <= req_wr;
                        size_q <= req_size;
                        off_q  <= req_addr[2:0];
                        if (al_misalign) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= StReq;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= req_wr;
                            bus_addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
                            bus_wdata_q <= al_wdata;
                            bus_wstrb_q <= al_wstrb;
                        end
                    end
                end
                StReq: begin
                    // A grant in the limit cycle takes priority over the timeout
                    if (bus.bus_gnt || cnt_q == CntLast) begin
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= '0;
                        bus_wdata_q <= '0;
                        bus_wstrb_q <= '0;
                    end
                    if (bus.bus_gnt) begin
                        if (wr_q) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWait: begin
                    if (bus.bus_rvalid) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        rd_data_q <= al_rdata;
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Released in DONE so the core retires the instruction at the end of that cycle
    assign stall = (in_idle && req_valid) || (state_q == StReq) || (state_q == StWait);

    assign done          = done_q;
    assign misalign      = misalign_q;
    assign bus_err       = bus_err_q;
    assign mem_rd_data   = rd_data_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu. Inputs change on the falling edge, outputs are
// checked 1 ns later; DUT state updates on the rising edge.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        stall;
    logic        done;
    logic        misalign;
    logic        bus_err;
    logic [63:0] mem_rd_data;

    int tests = 0;
    int fails = 0;

    lsu_if #(.ADDR_W(64)) bus_if ();

    lsu #(
        .TIMEOUT_CYCLES (8),
        .ADDR_W         (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .done        (done),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .mem_rd_data (mem_rd_data),
        .bus         (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [63:0] addr,
                         input logic [63:0] wd);
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_wr = 0; req_size = 0; req_addr = 0; req_wdata = 0;
        bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;
        cyc(); cyc(); #1;
        tests++;
        if ({stall, done, misalign, bus_err, bus_if.bus_req, bus_if.bus_we} !== 6'b0 ||
            mem_rd_data !== 64'h0 || bus_if.bus_addr !== 64'h0 ||
            bus_if.bus_wdata !== 64'h0 || bus_if.bus_wstrb !== 8'h0) begin
            fails++;
            $display("FAIL reset_outputs: got stall=%b done=%b req=%b rd=%h want all zero",
                     stall, done, bus_if.bus_req, mem_rd_data);
        end
        rst = 1'b0;
        cyc(); #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL idle_no_stall: got %b want 0", stall);
        end
    endtask

    task automatic test_load_word();
        cyc(); issue(1'b0, SZ_W, 64'h1004, 64'h0); #1;
        tests++;
        if ({stall, bus_if.bus_req} !== 2'b10) begin
            fails++; $display("FAIL lw_t0: got stall,req=%b want 10", {stall, bus_if.bus_req});
        end
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        tests++;
        if ({bus_if.bus_req, bus_if.bus_we, stall} !== 3'b101 || bus_if.bus_addr !== 64'h1000)
        begin
            fails++; $display("FAIL lw_req: got req,we,stall=%b addr=%h want 101 1000",
                              {bus_if.bus_req, bus_if.bus_we, stall}, bus_if.bus_addr);
        end
        cyc(); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1;
        bus_if.bus_rdata = 64'hAABBCCDD_11223344; #1;
        tests++;
        if ({bus_if.bus_req, stall, done} !== 3'b010) begin
            fails++; $display("FAIL lw_wait: got req,stall,done=%b want 010",
                              {bus_if.bus_req, stall, done});
        end
        cyc(); bus_if.bus_rvalid = 0; #1;
        tests++;
        if ({done, misalign, bus_err, stall} !== 4'b1000 ||
            mem_rd_data !== 64'h00000000_AABBCCDD) begin
            fails++; $display("FAIL lw_done: got flags=%b data=%h want 1000 00000000aabbccdd",
                              {done, misalign, bus_err, stall}, mem_rd_data);
        end
        cyc(); #1;
        tests++;
        if (done !== 1'b0 || mem_rd_data !== 64'h0) begin
            fails++; $display("FAIL lw_pulse: got done=%b data=%h want 0 0", done, mem_rd_data);
        end
    endtask

    task automatic test_store_byte();
        cyc(); issue(1'b1, SZ_B, 64'h2003, 64'hFFFFFFFF_FFFFFF5A); #1;
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        tests++;
        if ({bus_if.bus_req, bus_if.bus_we} !== 2'b11 || bus_if.bus_addr !== 64'h2000 ||
            bus_if.bus_wstrb !== 8'h08 || bus_if.bus_wdata !== 64'hFFFFFFFF_5A000000) begin
            fails++; $display("FAIL sb_req: got strb=%h wdata=%h addr=%h want 08 ffffffff5a000000 2000",
                              bus_if.bus_wstrb, bus_if.bus_wdata, bus_if.bus_addr);
        end
        cyc(); bus_if.bus_gnt = 0; #1;
        tests++;
        if ({done, misalign, bus_err, stall, bus_if.bus_req} !== 5'b10000 ||
            mem_rd_data !== 64'h0) begin
            fails++; $display("FAIL sb_done: got flags=%b data=%h want 10000 0",
                              {done, misalign, bus_err, stall, bus_if.bus_req}, mem_rd_data);
        end
    endtask

    task automatic test_misalign();
        cyc(); issue(1'b0, SZ_H, 64'h3001, 64'h0); #1;
        cyc(); req_valid = 0; #1;
        tests++;
        if ({done, misalign, bus_err, bus_if.bus_req, stall} !== 5'b11000 ||
            mem_rd_data !== 64'h0) begin
            fails++; $display("FAIL lh_misalign: got flags=%b data=%h want 11000 0",
                              {done, misalign, bus_err, bus_if.bus_req, stall}, mem_rd_data);
        end
        cyc(); #1;
        tests++;
        if ({done, misalign, bus_if.bus_req} !== 3'b000) begin
            fails++; $display("FAIL lh_after: got %b want 000", {done, misalign, bus_if.bus_req});
        end
        // Word store on a half-word boundary
        cyc(); issue(1'b1, SZ_W, 64'h3002, 64'h1234); #1;
        cyc(); req_valid = 0; #1;
        tests++;
        if ({done, misalign, bus_if.bus_req} !== 3'b110) begin
            fails++; $display("FAIL sw_misalign: got %b want 110", {done, misalign, bus_if.bus_req});
        end
    endtask

    task automatic test_delayed_ld();
        cyc(); issue(1'b0, SZ_D, 64'h4008, 64'h0); #1;
        for (int i = 1; i <= 5; i++) begin
            cyc(); req_valid = 0;
            if (i == 5) bus_if.bus_gnt = 1;
            #1;
            tests++;
            if ({bus_if.bus_req, done} !== 2'b10 || bus_if.bus_addr !== 64'h4008) begin
                fails++; $display("FAIL ld_req_hold%0d: got req,done=%b addr=%h want 10 4008",
                                  i, {bus_if.bus_req, done}, bus_if.bus_addr);
            end
        end
        cyc(); bus_if.bus_gnt = 0; #1;
        cyc(); bus_if.bus_rvalid = 1; bus_if.bus_rdata = 64'h01234567_89ABCDEF; #1;
        tests++;
        if ({bus_if.bus_req, stall, done} !== 3'b010) begin
            fails++; $display("FAIL ld_wait: got %b want 010", {bus_if.bus_req, stall, done});
        end
        cyc(); bus_if.bus_rvalid = 0; #1;
        tests++;
        if (done !== 1'b1 || mem_rd_data !== 64'h01234567_89ABCDEF) begin
            fails++; $display("FAIL ld_done_t8: got done=%b data=%h want 1 0123456789abcdef",
                              done, mem_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        cyc(); issue(1'b1, SZ_D, 64'h5000, 64'hDEADBEEF_0BADF00D); #1;
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        tests++;
        if (bus_if.bus_wstrb !== 8'hFF || bus_if.bus_wdata !== 64'hDEADBEEF_0BADF00D) begin
            fails++; $display("FAIL sd_req: got strb=%h wdata=%h want ff deadbeef0badf00d",
                              bus_if.bus_wstrb, bus_if.bus_wdata);
        end
        // Next instruction presented during DONE: must not be taken until IDLE
        cyc(); bus_if.bus_gnt = 0; issue(1'b0, SZ_H, 64'h5006, 64'h0); #1;
        tests++;
        if ({done, stall} !== 2'b10) begin
            fails++; $display("FAIL b2b_done: got done,stall=%b want 10", {done, stall});
        end
        cyc(); #1;
        tests++;
        if ({stall, bus_if.bus_req, done} !== 3'b100) begin
            fails++; $display("FAIL b2b_accept: got %b want 100", {stall, bus_if.bus_req, done});
        end
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        tests++;
        if ({bus_if.bus_req, bus_if.bus_we} !== 2'b10 || bus_if.bus_addr !== 64'h5000 ||
            bus_if.bus_wstrb !== 8'hC0) begin
            fails++; $display("FAIL lh_req: got addr=%h strb=%h want 5000 c0",
                              bus_if.bus_addr, bus_if.bus_wstrb);
        end
        cyc(); bus_if.bus_gnt = 0; bus_if.bus_rvalid = 1;
        bus_if.bus_rdata = 64'h11223344_55667788; #1;
        cyc(); bus_if.bus_rvalid = 0; #1;
        tests++;
        if (done !== 1'b1 || mem_rd_data !== 64'h1122) begin
            fails++; $display("FAIL lh_data: got done=%b data=%h want 1 1122", done, mem_rd_data);
        end
    endtask

    task automatic test_timeout();
        cyc(); issue(1'b0, SZ_W, 64'h6000, 64'h0); #1;
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        cyc(); bus_if.bus_gnt = 0; #1;
        for (int i = 3; i <= 9; i++) begin
            cyc(); #1;
        end
        tests++;
        if ({done, stall} !== 2'b01) begin
            fails++; $display("FAIL to_wait8: got done,stall=%b want 01", {done, stall});
        end
        cyc(); #1;
        tests++;
        if ({done, bus_err, misalign, stall} !== 4'b1100 || mem_rd_data !== 64'h0) begin
            fails++; $display("FAIL to_err: got flags=%b data=%h want 1100 0",
                              {done, bus_err, misalign, stall}, mem_rd_data);
        end
        cyc(); bus_if.bus_rvalid = 1; bus_if.bus_rdata = 64'hCAFEF00D_CAFEF00D; #1;
        cyc(); bus_if.bus_rvalid = 0; #1;
        tests++;
        if ({done, bus_err, stall, bus_if.bus_req} !== 4'b0000 || mem_rd_data !== 64'h0) begin
            fails++; $display("FAIL to_late_rvalid: got flags=%b data=%h want 0000 0",
                              {done, bus_err, stall, bus_if.bus_req}, mem_rd_data);
        end
        // Grant never arrives: abort after 8 REQ cycles
        cyc(); issue(1'b1, SZ_D, 64'h6100, 64'h77); #1;
        for (int i = 1; i <= 8; i++) begin
            cyc(); req_valid = 0; #1;
        end
        tests++;
        if ({bus_if.bus_req, done} !== 2'b10) begin
            fails++; $display("FAIL to_req8: got req,done=%b want 10", {bus_if.bus_req, done});
        end
        cyc(); #1;
        tests++;
        if ({done, bus_err, bus_if.bus_req, stall} !== 4'b1100) begin
            fails++; $display("FAIL to_req_err: got %b want 1100",
                              {done, bus_err, bus_if.bus_req, stall});
        end
    endtask

    task automatic test_rvalid_at_limit();
        cyc(); issue(1'b0, SZ_W, 64'h6004, 64'h0); #1;
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        cyc(); bus_if.bus_gnt = 0; #1;
        for (int i = 3; i <= 9; i++) begin
            cyc();
            if (i == 9) begin
                bus_if.bus_rvalid = 1; bus_if.bus_rdata = 64'h55667788_99AABBCC;
            end
            #1;
        end
        cyc(); bus_if.bus_rvalid = 0; #1;
        tests++;
        if ({done, bus_err} !== 2'b10 || mem_rd_data !== 64'h55667788) begin
            fails++; $display("FAIL limit_rvalid: got done,err=%b data=%h want 10 55667788",
                              {done, bus_err}, mem_rd_data);
        end
    endtask

    task automatic test_reset_mid();
        cyc(); issue(1'b0, SZ_W, 64'h7000, 64'h0); #1;
        cyc(); req_valid = 0; bus_if.bus_gnt = 1; #1;
        cyc(); bus_if.bus_gnt = 0; rst = 1; #1;
        cyc(); rst = 0; bus_if.bus_rvalid = 1; bus_if.bus_rdata = 64'hFFFFFFFF_FFFFFFFF; #1;
        tests++;
        if ({stall, done, misalign, bus_err, bus_if.bus_req} !== 5'b0 || mem_rd_data !== 64'h0)
        begin
            fails++; $display("FAIL rst_mid: got flags=%b data=%h want 00000 0",
                              {stall, done, misalign, bus_err, bus_if.bus_req}, mem_rd_data);
        end
        cyc(); bus_if.bus_rvalid = 0; #1;
        tests++;
        if ({stall, done, bus_if.bus_req} !== 3'b0 || mem_rd_data !== 64'h0) begin
            fails++; $display("FAIL rst_no_done: got flags=%b data=%h want 000 0",
                              {stall, done, bus_if.bus_req}, mem_rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_misalign();
        test_delayed_ld();
        test_back_to_back();
        test_timeout();
        test_rvalid_at_limit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
